wide_add_sequencer: RTL and testbench

WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

---
 rtl/wide_add_sequencer.sv | 133 +++++++++++++
 tb/tb_wide_add_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer.sv
// Multi-word adder that streams one 32-bit operand word per cycle through an external adder.
// Define WIDE_ADD_OVF_EN to add the registered signed-overflow output ovf.
module wide_add_sequencer #(
  parameter int unsigned NUM_WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [32*NUM_WORDS-1:0] op_a,
  input  logic [32*NUM_WORDS-1:0] op_b,
  input  logic                   cin,
  output logic [31:0]            adder_a,
  output logic [31:0]            adder_b,
  output logic                   adder_cin,
  input  logic [31:0]            adder_s,
  input  logic                   adder_cout,
  output logic [32*NUM_WORDS-1:0] sum,
  output logic                   cout,
  output logic                   busy,
  output logic                   done
`ifdef WIDE_ADD_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int unsigned Width = 32 * NUM_WORDS;
  localparam int unsigned IdxW  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  logic [Width-1:0] r_op_a;
  logic [Width-1:0] r_op_b;
  logic [Width-1:0] r_sum;
  logic [IdxW-1:0]  r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic [31:0]      w_word_a;
  logic [31:0]      w_word_b;
  logic             w_run;
`ifdef WIDE_ADD_OVF_EN
  logic             r_ovf;
`endif

  always_comb begin
    w_word_a = '0;
    w_word_b = '0;
    for (int unsigned i = 0; i < NUM_WORDS; i++) begin
      if (r_idx == IdxW'(i)) begin
        w_word_a = r_op_a[32*i +: 32];
        w_word_b = r_op_b[32*i +: 32];
      end
    end
  end

  // Adder inputs come only from registers and are forced to zero outside RUN.
  assign w_run     = (r_state == StRun);
  assign adder_a   = w_run ? w_word_a : 32'd0;
  assign adder_b   = w_run ? w_word_b : 32'd0;
  assign adder_cin = w_run ? r_carry : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef WIDE_ADD_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_op_a  <= op_a;
            r_op_b  <= op_b;
            r_idx   <= '0;
            r_carry <= cin;
            r_busy  <= 1'b1;
            r_state <= StRun;
          end
        end
        StRun: begin
          for (int unsigned i = 0; i < NUM_WORDS; i++) begin
            if (r_idx == IdxW'(i)) begin
              r_sum[32*i +: 32] <= adder_s;
            end
          end
          r_carry <= adder_cout;
          if (r_idx == LastIdx) begin
            r_idx   <= '0;
            r_cout  <= adder_cout;
`ifdef WIDE_ADD_OVF_EN
            // Carry into bit 31 is recovered as s ^ a ^ b at that bit.
            r_ovf   <= adder_cout ^ (adder_s[31] ^ adder_a[31] ^ adder_b[31]);
`endif
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_idx <= r_idx + IdxW'(1);
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign busy = r_busy;
  assign done = r_done;
`ifdef WIDE_ADD_OVF_EN
  assign ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: a 4-word instance and a 1-word instance, each
// paired with a behavioural 32-bit adder, checked against a scoreboard of reference sums.
module tb_wide_add_sequencer;

  localparam int unsigned NW = 4;
  localparam int unsigned W  = 32 * NW;

  typedef struct packed {
    logic [W:0] res;
    logic       ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // 4-word instance
  logic         start = 1'b0;
  logic [W-1:0] op_a  = '0;
  logic [W-1:0] op_b  = '0;
  logic         cin   = 1'b0;
  logic [31:0]  adder_a, adder_b, adder_s;
  logic         adder_cin, adder_cout;
  logic [W-1:0] sum;
  logic         cout, busy, done;
  logic         ovf;

  // 1-word instance
  logic         start_1 = 1'b0;
  logic [31:0]  op_a_1  = '0;
  logic [31:0]  op_b_1  = '0;
  logic         cin_1   = 1'b0;
  logic [31:0]  adder_a_1, adder_b_1, adder_s_1;
  logic         adder_cin_1, adder_cout_1;
  logic [31:0]  sum_1;
  logic         cout_1, busy_1, done_1;
  logic         ovf_1;

  assign {adder_cout, adder_s}     = {1'b0, adder_a} + {1'b0, adder_b} + {32'd0, adder_cin};
  assign {adder_cout_1, adder_s_1} = {1'b0, adder_a_1} + {1'b0, adder_b_1}
                                     + {32'd0, adder_cin_1};

  wide_add_sequencer #(.NUM_WORDS(NW)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .cin        (cin),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_cin  (adder_cin),
    .adder_s    (adder_s),
    .adder_cout (adder_cout),
    .sum        (sum),
    .cout       (cout),
    .busy       (busy),
`ifdef WIDE_ADD_OVF_EN
    .ovf        (ovf),
`endif
    .done       (done)
  );

  wide_add_sequencer #(.NUM_WORDS(1)) u_dut_1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start_1),
    .op_a       (op_a_1),
    .op_b       (op_b_1),
    .cin        (cin_1),
    .adder_a    (adder_a_1),
    .adder_b    (adder_b_1),
    .adder_cin  (adder_cin_1),
    .adder_s    (adder_s_1),
    .adder_cout (adder_cout_1),
    .sum        (sum_1),
    .cout       (cout_1),
    .busy       (busy_1),
`ifdef WIDE_ADD_OVF_EN
    .ovf        (ovf_1),
`endif
    .done       (done_1)
  );

`ifndef WIDE_ADD_OVF_EN
  assign ovf   = 1'b0;
  assign ovf_1 = 1'b0;
`endif

  int          checks = 0;
  int          errors = 0;
  exp_t        q4[$];
  logic [32:0] q1[$];
  logic [3:0]  last_cins;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t e;
    e.res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    e.ovf = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    q4.push_back(model(a, b, c));
    tick();
    start = 1'b0;
  endtask

  // Counts edges from the current point until done is seen; records adder_cin per RUN cycle.
  task automatic wait_done(output int lat);
    lat       = 0;
    last_cins = '0;
    while (!done && lat < 40) begin
      if (lat < 4) last_cins[lat] = adder_cin;
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    if (q4.size() == 0) begin
      chk({tag, "_sb_empty"}, (W+1)'(0), (W+1)'(1));
    end else begin
      e = q4.pop_front();
      chk({tag, "_sum"}, {cout, sum}, e.res);
`ifdef WIDE_ADD_OVF_EN
      chk({tag, "_ovf"}, (W+1)'(ovf), (W+1)'(e.ovf));
`endif
    end
  endtask

  task automatic check_after(input string tag);
    tick();
    chk({tag, "_done_pulse"}, (W+1)'({done, busy}), (W+1)'(0));
    chk({tag, "_adder_idle"}, (W+1)'({adder_a, adder_b, adder_cin}), (W+1)'(0));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c);
    int lat;
    drive_start(a, b, c);
    wait_done(lat);
    chk({tag, "_latency"}, (W+1)'(lat), (W+1)'(NW));
    check_result(tag);
    check_after(tag);
  endtask

  initial begin
    int          lat;
    int          n;
    logic        seen;
    logic [W-1:0] ra, rb;
    exp_t        junk;

    // Reset state
    #1 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_outputs", (W+1)'({busy, done, cout}), (W+1)'(0));
    chk("rst_sum", (W+1)'(sum), (W+1)'(0));
    chk("rst_adder", (W+1)'({adder_a, adder_b, adder_cin}), (W+1)'(0));
    chk("rst_dut1", (W+1)'({sum_1, cout_1, busy_1, done_1}), (W+1)'(0));
    rst_n = 1'b1;
    tick();

    // All-ones plus carry-in: carry ripples through every word
    run_op("ones_cin", {W{1'b1}}, '0, 1'b1);
    chk("ones_cin_chain", (W+1)'(last_cins), (W+1)'(4'hF));

    run_op("chain_a", 128'h00000001_FFFFFFFF_FFFFFFFF_00000000,
           128'h00000000_00000000_00000000_FFFFFFFF, 1'b1);
    run_op("chain_b", 128'h00000001_FFFFFFFF_FFFFFFFF_00000000,
           128'hFFFFFFFF_00000000_00000001_00000000, 1'b0);

    for (int i = 0; i < 200; i++) begin
      for (int w = 0; w < NW; w++) begin
        ra[32*w +: 32] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom());
        rb[32*w +: 32] = ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom());
      end
      run_op("random", ra, rb, 1'($urandom_range(0, 1)));
    end

    // start held high; operand change after latching must not leak into the first result
    op_a  = 128'h12345678_9ABCDEF0_0F0F0F0F_F0F0F0F0;
    op_b  = 128'h11111111_22222222_33333333_44444444;
    cin   = 1'b0;
    start = 1'b1;
    q4.push_back(model(op_a, op_b, cin));
    tick();
    op_a = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    op_b = 128'h00000000_00000000_00000000_00000002;
    cin  = 1'b1;
    q4.push_back(model(op_a, op_b, cin));
    wait_done(lat);
    chk("hold_latency", (W+1)'(lat), (W+1)'(NW));
    check_result("hold_first");
    check_after("hold_first");
    // One edge already passed after done; the restart adds IDLE accept plus NW RUN edges.
    wait_done(n);
    chk("hold_respacing", (W+1)'(n), (W+1)'(NW + 1));
    check_result("hold_second");
    start = 1'b0;
    check_after("hold_second");

    // Reset asserted in the second RUN cycle
    drive_start(128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD,
                128'h11111111_11111111_11111111_11111111, 1'b1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrun_rst", (W+1)'({busy, done, cout}), (W+1)'(0));
    chk("midrun_rst_sum", (W+1)'(sum), (W+1)'(0));
    junk = q4.pop_back();
    tick();
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | done | busy;
    end
    chk("midrun_no_done", (W+1)'(seen), (W+1)'(0));
    run_op("after_rst", 128'h00000000_00000000_FFFFFFFF_FFFFFFFF,
           128'h00000000_00000000_00000000_00000001, 1'b0);

    // Signed overflow corners (ovf checked through the scoreboard when enabled)
    run_op("ovf_pos", 128'h7FFFFFFF_00000000_00000000_00000000,
           128'h00000001_00000000_00000000_00000000, 1'b0);
    run_op("ovf_neg", 128'h80000000_00000000_00000000_00000000,
           128'h80000000_00000000_00000000_00000000, 1'b0);

    // Single-word instance
    op_a_1  = 32'hFFFF_FFFF;
    op_b_1  = 32'h0000_0001;
    cin_1   = 1'b0;
    start_1 = 1'b1;
    q1.push_back({1'b0, op_a_1} + {1'b0, op_b_1} + {32'd0, cin_1});
    tick();
    start_1 = 1'b0;
    n = 0;
    while (!done_1 && n < 20) begin
      tick();
      n++;
    end
    chk("w1_latency", (W+1)'(n), (W+1)'(1));
    chk("w1_sum", (W+1)'({cout_1, sum_1}), (W+1)'(q1.pop_front()));
    tick();
    chk("w1_done_pulse", (W+1)'({done_1, busy_1}), (W+1)'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
